truth_table_prober: RTL
=======================

# truth_table_prober

Sequential stimulus driver and response capture for small combinational logic blocks, such as the 2-input/1-output function modules in this codebase.
- On `start`, it walks every input combination in ascending order, drives each onto the device under test (DUT) inputs, waits a programmable settle time and samples the DUT output.
- It assembles the full truth table and compares it against an expected table latched at start.
- It sits on the driving side of the DUT, in self-test and bring-up harnesses, replacing hand-written stimulus.

## Interface
Parameters:
- `N_IN`, 2: DUT input width; the table has 2**N_IN entries. Legal range 1..6.
- `SETTLE`, 1: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a sweep; accepted only in IDLE.
- `expected`  input  2**N_IN  expected table; bit i is the expected output for input value i. Latched on start acceptance.
- `dut_in`  output  N_IN  registered stimulus. For N_IN=2, bit1 drives x and bit0 drives y.
- `dut_out`  input  1  DUT response; must be combinational from `dut_in`.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse when the sweep completes.
- `table_out`  output  2**N_IN  captured table; bit i is the response to input value i.
- `mismatch`  output  1  set if any captured bit differs from the latched expected bit.
- `fail_index`  output  N_IN  lowest index that mismatched; 0 if none.

## Operation
States: IDLE, APPLY, SAMPLE, DONE.

Reset values: state IDLE; `dut_in`=0, `busy`=0, `done`=0, `table_out`=0, `mismatch`=0, `fail_index`=0.

IDLE, start seen:
- Latch `expected`.
- Clear `table_out`, `mismatch` and `fail_index`.
- Set index=0, `dut_in`=0, settle counter=0; go to APPLY.

APPLY:
- Increment the counter each cycle.
- When counter==SETTLE-1, go to SAMPLE. APPLY therefore lasts exactly SETTLE cycles.

SAMPLE, at the leaving edge:
- Capture `table_out[index]` <= `dut_out`.
- If `dut_out` != expected[index] and `mismatch` is still 0: set `mismatch`=1 and `fail_index`=index.
- If index is not the last (2**N_IN-1): increment index and `dut_in`, reset the counter, go to APPLY.
- Otherwise go to DONE; `dut_in` keeps its last value.

DONE: `done`=1 for this single cycle, then go to IDLE.

Boundary rules:
- `start` in any state other than IDLE is ignored; no queuing.
- `start` held high continuously restarts a sweep on the cycle after DONE.
- Results (`table_out`, `mismatch`, `fail_index`) hold until the next accepted start.
- Index arithmetic is N_IN+1 bits wide so the last-index compare cannot wrap.
- Changes on `expected` after start acceptance have no effect on the sweep.
- `rst_n` asserted mid-sweep forces all reset values immediately, asynchronously; no partial results survive.

## Timing
- Start accepted at edge E0; vector v is driven from edge E0 + v*(SETTLE+1).
- `dut_out` for vector v is sampled at edge E0 + v*(SETTLE+1) + SETTLE + 1.
- `done` is high in the cycle after edge E0 + 2**N_IN*(SETTLE+1).
  - Default parameters: `done` high in the cycle after edge E0+8.
- `busy` rises the cycle after E0 and falls when DONE exits.
- `table_out` and `mismatch` are final no later than the cycle in which `done` is high.

## Configuration
- `PROBER_STOP_ON_FAIL_EN` defined: on the first mismatch, SAMPLE goes directly to DONE.
  - `done` pulses early.
  - Untested `table_out` bits remain 0.
- Not defined: the full sweep always runs, and `fail_index` still reports the first failure.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0, `busy`=0.
- Default parameters; DUT z=(A|B)^(A&B) with A=x&~y, B=x XNOR y; `expected`=4'b1101 → `done` one cycle after E0+8, `table_out`=4'b1101, `mismatch`=0, `fail_index`=0.
- Same DUT with `expected`=4'b1001 → `mismatch`=1, `fail_index`=2.
  - Macro undefined: `table_out`=4'b1101.
  - Macro defined: `done` after E0+6, `table_out`=4'b0101.
- SETTLE=3 with XNOR DUT and `expected`=4'b1001 → `done` after E0+16.
  - `dut_in` takes each of 0..3 for 4 cycles.
  - `mismatch`=0.
- `start` pulsed in mid-sweep (E0+3) → ignored; `start` held high → a second sweep begins the cycle after `done`, and `table_out` clears on acceptance.
- `rst_n` dropped at E0+5 → `dut_in`, `busy`, `table_out` go to 0 immediately; no `done` pulse.

Source files
------------

// File: rtl/truth_table_prober.sv
// truth_table_prober: walks every input combination of a small combinational DUT,
// captures its truth table and compares it with an expected table. Optional macro: PROBER_STOP_ON_FAIL_EN.
module truth_table_prober #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    table_out,
  output logic                    mismatch,
  output logic [N_IN-1:0]         fail_index
);

  localparam int TBL = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX    = (N_IN+1)'(TBL - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [N_IN:0]       idx_q, idx_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic [TBL-1:0]      exp_q, exp_d;
  logic [TBL-1:0]      tbl_q, tbl_d;
  logic                mis_q, mis_d;
  logic [N_IN-1:0]     fidx_q, fidx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_now_s;
  logic                stop_s;

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dut_in_d = dut_in_q;
    exp_d    = exp_q;
    tbl_d    = tbl_q;
    mis_d    = mis_q;
    fidx_d   = fidx_q;

    // Only the first failing index is recorded, so later mismatches are masked.
    fail_now_s = (dut_out != exp_q[idx_q[N_IN-1:0]]) && !mis_q;
`ifdef PROBER_STOP_ON_FAIL_EN
    stop_s = fail_now_s;
`else
    stop_s = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expected;
          tbl_d    = '0;
          mis_d    = 1'b0;
          fidx_d   = '0;
          idx_d    = '0;
          dut_in_d = '0;
          cnt_d    = 4'd0;
          state_d  = S_APPLY;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          state_d = S_APPLY;
        end
      end
      S_SAMPLE: begin
        tbl_d[idx_q[N_IN-1:0]] = dut_out;
        if (fail_now_s) begin
          mis_d  = 1'b1;
          fidx_d = idx_q[N_IN-1:0];
        end else begin
          mis_d  = mis_q;
        end
        if ((idx_q != LAST_IDX) && !stop_s) begin
          idx_d    = idx_q + (N_IN+1)'(1);
          dut_in_d = idx_d[N_IN-1:0];
          cnt_d    = 4'd0;
          state_d  = S_APPLY;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and result registers; reset clears everything including partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      dut_in_q <= '0;
      exp_q    <= '0;
      tbl_q    <= '0;
      mis_q    <= 1'b0;
      fidx_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      exp_q    <= exp_d;
      tbl_q    <= tbl_d;
      mis_q    <= mis_d;
      fidx_q   <= fidx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = tbl_q;
  assign mismatch   = mis_q;
  assign fail_index = fidx_q;

endmodule
